gpioemu_mulpop: RTL and testbench

Parametrised successor of the bus-mapped multiply/popcount emulation peripheral. It sits on the simple host bus (saddress/srd/swr/sdata) and accepts two WIDTH-bit operands. On a start write it runs a bit-serial shift-add multiply, then a popcount of the product. It exposes the low product word, the popcount, a status word and an operation counter on gpio_out. Unlike the previous generation, the operand width and base address are parameters, operands are snapshotted at start, and start-while-busy is detected. Everything runs on one clock.

---
 rtl/gpioemu_mulpop.sv | 205 ++++++++++++++++++++
 tb/tb_gpioemu_mulpop.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/gpioemu_mulpop.sv
// gpioemu_mulpop: bus-mapped multiply/popcount peripheral.
// Two WIDTH-bit operands are snapshotted on a start write, multiplied with a
// bit-serial shift-add (one operand-B bit per cycle), then the product is
// popcounted in a single cycle. Results, status and an operation counter are
// readable on the host bus; the counter also appears on gpio_out.
// Optional feature: define MULPOP_HIWORD_EN to map product[2*WIDTH-1:32] at +0x28.
//
// Handshake: srd/swr are level strobes; an access is taken only on the clock
// edge where the strobe is 1 and its registered previous value is 0. A read
// registers sdata_out on that edge from pre-edge state, so a simultaneous
// write to the same address is not visible in the returned data.
module gpioemu_mulpop #(
  parameter int          WIDTH = 24,
  parameter logic [15:0] BASE  = 16'h0380
) (
  input  logic        clk,
  input  logic        n_reset,
  input  logic [15:0] saddress,
  input  logic        srd,
  input  logic        swr,
  input  logic [31:0] sdata_in,
  output logic [31:0] sdata_out,
  input  logic [31:0] gpio_in,
  input  logic        gpio_latch,
  output logic [31:0] gpio_in_s_insp,
  output logic [31:0] gpio_out,
  output logic [1:0]  state_dbg
);

  localparam int PW = 2 * WIDTH;
  localparam int LW = $clog2(PW + 1);
  localparam int IW = $clog2(WIDTH);

  localparam logic [15:0] ADDR_A1 = BASE;
  localparam logic [15:0] ADDR_A2 = BASE + 16'h0008;
  localparam logic [15:0] ADDR_W  = BASE + 16'h0010;
  localparam logic [15:0] ADDR_L  = BASE + 16'h0018;
  localparam logic [15:0] ADDR_ST = BASE + 16'h0020;
`ifdef MULPOP_HIWORD_EN
  localparam logic [15:0] ADDR_HI = BASE + 16'h0028;
`endif

  typedef enum logic [1:0] {S_IDLE, S_MULT, S_POP, S_DONE} state_t;

  state_t          state_q, state_d;
  logic            srd_prev_q, swr_prev_q;
  logic [WIDTH-1:0] a1_q, a2_q;
  logic [WIDTH-1:0] a1_w_q, b_w_q;
  logic [PW-1:0]   acc_q;
  logic [IW-1:0]   idx_q;
  logic [31:0]     w_q;
  logic [LW-1:0]   l_q;
  logic            done_q, valid_q, overrun_q;
  logic [15:0]     op_cnt_q;
  logic [31:0]     sdata_out_q;
  logic [31:0]     gpio_in_s_q;
`ifdef MULPOP_HIWORD_EN
  logic [31:0]     hi_q;
`endif

  logic            rd_ev, wr_ev, start_ev;
  logic            busy, ld_start, mult_en, pop_en, done_en, ovr_set;
  logic [PW-1:0]   addend;
  logic [63:0]     acc_ext;
  logic [31:0]     prod_lo, prod_hi;
  logic [LW-1:0]   pop_cnt;
  logic [31:0]     rd_data;
  logic            unused_ok;

  assign rd_ev    = srd & ~srd_prev_q;
  assign wr_ev    = swr & ~swr_prev_q;
  assign start_ev = wr_ev && (saddress == ADDR_ST);
  assign ovr_set  = start_ev && busy;

  assign acc_ext  = 64'(acc_q);
  assign prod_lo  = acc_ext[31:0];
  assign prod_hi  = acc_ext[63:32];
  assign addend   = b_w_q[idx_q] ? (PW'(a1_w_q) << idx_q) : '0;
  assign unused_ok = ^sdata_in;

  // State register.
  always_ff @(posedge clk) begin
    if (!n_reset) state_q <= S_IDLE;
    else          state_q <= state_d;
  end

  // Next-state logic: IDLE -> MULT (WIDTH cycles) -> POP -> DONE -> IDLE.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (start_ev) state_d = S_MULT;
      S_MULT:  if (idx_q == IW'(WIDTH - 1)) state_d = S_POP;
      S_POP:   state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Per-state control strobes for the datapath.
  always_comb begin
    busy     = 1'b0;
    ld_start = 1'b0;
    mult_en  = 1'b0;
    pop_en   = 1'b0;
    done_en  = 1'b0;
    case (state_q)
      S_IDLE:  ld_start = start_ev;
      S_MULT:  begin busy = 1'b1; mult_en = 1'b1; end
      S_POP:   begin busy = 1'b1; pop_en  = 1'b1; end
      S_DONE:  begin busy = 1'b1; done_en = 1'b1; end
      default: ;
    endcase
  end

  // Single-cycle popcount of the full-width accumulator.
  always_comb begin
    pop_cnt = '0;
    for (int i = 0; i < PW; i++) pop_cnt = pop_cnt + LW'(acc_q[i]);
  end

  // Read mux; unmapped addresses return zero.
  always_comb begin
    rd_data = 32'h0;
    case (saddress)
      ADDR_W:  rd_data = w_q;
      ADDR_L:  rd_data = 32'(l_q);
      ADDR_ST: rd_data = {28'h0, overrun_q, busy, done_q, valid_q};
`ifdef MULPOP_HIWORD_EN
      ADDR_HI: rd_data = hi_q;
`endif
      default: rd_data = 32'h0;
    endcase
  end

  // Bus side: strobe history, operand registers, read data, gpio capture.
  always_ff @(posedge clk) begin
    if (!n_reset) begin
      srd_prev_q  <= 1'b0;
      swr_prev_q  <= 1'b0;
      a1_q        <= '0;
      a2_q        <= '0;
      sdata_out_q <= 32'h0;
      gpio_in_s_q <= 32'h0;
    end else begin
      srd_prev_q <= srd;
      swr_prev_q <= swr;
      if (wr_ev && saddress == ADDR_A1) a1_q <= sdata_in[WIDTH-1:0];
      if (wr_ev && saddress == ADDR_A2) a2_q <= sdata_in[WIDTH-1:0];
      if (rd_ev) sdata_out_q <= rd_data;
      if (gpio_latch) gpio_in_s_q <= gpio_in;
    end
  end

  // Operation datapath: snapshot, shift-add, result capture, status, counter.
  always_ff @(posedge clk) begin
    if (!n_reset) begin
      a1_w_q    <= '0;
      b_w_q     <= '0;
      acc_q     <= '0;
      idx_q     <= '0;
      w_q       <= 32'h0;
      l_q       <= '0;
      done_q    <= 1'b1;
      valid_q   <= 1'b1;
      overrun_q <= 1'b0;
      op_cnt_q  <= 16'h0;
`ifdef MULPOP_HIWORD_EN
      hi_q      <= 32'h0;
`endif
    end else begin
      if (ld_start) begin
        a1_w_q    <= a1_q;
        b_w_q     <= a2_q;
        acc_q     <= '0;
        idx_q     <= '0;
        done_q    <= 1'b0;
        valid_q   <= 1'b0;
        overrun_q <= 1'b0;
      end
      if (ovr_set) overrun_q <= 1'b1;
      if (mult_en) begin
        acc_q <= acc_q + addend;
        idx_q <= idx_q + IW'(1);
      end
      if (pop_en) begin
        w_q     <= prod_lo;
        l_q     <= pop_cnt;
        valid_q <= (prod_hi == 32'h0);
`ifdef MULPOP_HIWORD_EN
        hi_q    <= prod_hi;
`endif
      end
      if (done_en) begin
        done_q   <= 1'b1;
        op_cnt_q <= op_cnt_q + 16'h1;
      end
    end
  end

  assign sdata_out      = sdata_out_q;
  assign gpio_in_s_insp = gpio_in_s_q;
  assign gpio_out       = {16'h0, op_cnt_q};
  assign state_dbg      = state_q;

endmodule

// File: tb/tb_gpioemu_mulpop.sv
// Testbench for gpioemu_mulpop: directed bus transactions, a behavioural
// model of the register map and operation timing, a per-cycle compare
// process, and literal expectations for each scenario.
module tb_gpioemu_mulpop;

  localparam int          WIDTH = 24;
  localparam logic [15:0] BASE  = 16'h0380;
  localparam logic [31:0] MASK  = (WIDTH == 32) ? 32'hFFFF_FFFF : ((32'h1 << WIDTH) - 32'h1);

  // ---------------- clock / reset ----------------
  logic        clk = 1'b0;
  logic        n_reset = 1'b0;
  logic [15:0] saddress = 16'h0;
  logic        srd = 1'b0;
  logic        swr = 1'b0;
  logic [31:0] sdata_in = 32'h0;
  logic [31:0] sdata_out;
  logic [31:0] gpio_in = 32'h0;
  logic        gpio_latch = 1'b0;
  logic [31:0] gpio_in_s_insp;
  logic [31:0] gpio_out;
  logic [1:0]  state_dbg;

  always #5 clk = ~clk;

  gpioemu_mulpop #(.WIDTH(WIDTH), .BASE(BASE)) dut (
    .clk            (clk),
    .n_reset        (n_reset),
    .saddress       (saddress),
    .srd            (srd),
    .swr            (swr),
    .sdata_in       (sdata_in),
    .sdata_out      (sdata_out),
    .gpio_in        (gpio_in),
    .gpio_latch     (gpio_latch),
    .gpio_in_s_insp (gpio_in_s_insp),
    .gpio_out       (gpio_out),
    .state_dbg      (state_dbg)
  );

  int n_cmp = 0;
  int n_bad = 0;
  logic chk_en = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic [31:0] exp_q[$];
  logic [31:0] m_a1, m_a2, m_w, m_hi, m_sdata_out, m_gin;
  logic [63:0] m_prod;
  int          m_l, m_t;
  logic [15:0] m_opcnt;
  logic        m_busy, m_done, m_valid, m_ovr, m_srd_p, m_swr_p;

  function automatic logic [31:0] m_read(input logic [15:0] a);
    if (a == BASE + 16'h10) return m_w;
    if (a == BASE + 16'h18) return 32'(m_l);
    if (a == BASE + 16'h20) return {28'h0, m_ovr, m_busy, m_done, m_valid};
`ifdef MULPOP_HIWORD_EN
    if (a == BASE + 16'h28) return m_hi;
`endif
    return 32'h0;
  endfunction

  always @(posedge clk) begin
    logic rd_ev, wr_ev, was_busy;
    if (!n_reset) begin
      m_a1 = 0; m_a2 = 0; m_w = 0; m_hi = 0; m_l = 0; m_t = 0;
      m_sdata_out = 0; m_gin = 0; m_opcnt = 0;
      m_busy = 0; m_done = 1; m_valid = 1; m_ovr = 0;
      m_srd_p = 0; m_swr_p = 0;
      exp_q.delete();
    end else begin
      rd_ev = srd && !m_srd_p;
      wr_ev = swr && !m_swr_p;
      was_busy = m_busy;
      if (rd_ev) m_sdata_out = m_read(saddress);
      if (m_busy) begin
        m_t++;
        if (m_t == WIDTH + 1) begin
          m_w = m_prod[31:0];
          m_hi = m_prod[63:32];
          m_l = $countones(m_prod);
          m_valid = (m_hi == 0);
        end
        if (m_t == WIDTH + 2) begin
          m_busy = 0; m_done = 1; m_opcnt = m_opcnt + 16'h1;
        end
      end
      if (wr_ev) begin
        if (saddress == BASE) m_a1 = sdata_in & MASK;
        else if (saddress == BASE + 16'h08) m_a2 = sdata_in & MASK;
        else if (saddress == BASE + 16'h20) begin
          if (was_busy) m_ovr = 1;
          else begin
            m_prod = 64'(m_a1) * 64'(m_a2);
            m_busy = 1; m_t = 0; m_done = 0; m_valid = 0; m_ovr = 0;
            exp_q.push_back(m_prod[31:0]);
          end
        end
      end
      if (gpio_latch) m_gin = gpio_in;
      m_srd_p = srd;
      m_swr_p = swr;
    end
  end

  // Per-cycle compare against the model, away from the active edge.
  always @(negedge clk) begin
    if (chk_en) begin
      check("cyc_sdata_out", sdata_out, m_sdata_out);
      check("cyc_gpio_out", gpio_out, {16'h0, m_opcnt});
      check("cyc_gpio_in_s", gpio_in_s_insp, m_gin);
    end
  end

  // ---------------- driver tasks ----------------
  task automatic bus_write(input logic [15:0] a, input logic [31:0] d);
    saddress = a; sdata_in = d; swr = 1'b1;
    @(negedge clk);
    swr = 1'b0;
    @(negedge clk);
  endtask

  task automatic bus_read(input logic [15:0] a, output logic [31:0] d);
    saddress = a; srd = 1'b1;
    @(negedge clk);
    srd = 1'b0;
    @(negedge clk);
    d = sdata_out;
  endtask

  task automatic bus_rw(input logic [15:0] a, input logic [31:0] wd, output logic [31:0] d);
    saddress = a; sdata_in = wd; srd = 1'b1; swr = 1'b1;
    @(negedge clk);
    srd = 1'b0; swr = 1'b0;
    @(negedge clk);
    d = sdata_out;
  endtask

  // Poll status until busy clears (bounded), then score W against the queue.
  task automatic finish_op(input string name);
    logic [31:0] d;
    for (int i = 0; i < 40; i++) begin
      bus_read(BASE + 16'h20, d);
      if (!d[2]) break;
    end
    check({name, "_idle"}, {31'h0, d[2]}, 32'h0);
    bus_read(BASE + 16'h10, d);
    if (exp_q.size() == 0) check({name, "_sb_empty"}, 32'(exp_q.size()), 32'h1);
    else check({name, "_sb_W"}, d, exp_q.pop_front());
  endtask

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: bench did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  // ---------------- directed stimulus ----------------
  initial begin
    logic [31:0] d;
    n_reset = 1'b0;
    repeat (2) @(negedge clk);
    chk_en = 1'b1;
    check("rst_sdata_out", sdata_out, 32'h0);
    check("rst_gpio_out", gpio_out, 32'h0);
    n_reset = 1'b1;
    bus_read(BASE + 16'h20, d); check("rst_status", d, 32'h3);
    bus_read(BASE + 16'h10, d); check("rst_W", d, 32'h0);

    // gpio capture
    gpio_in = 32'hDEAD_BEEF; gpio_latch = 1'b1;
    @(negedge clk);
    gpio_latch = 1'b0; gpio_in = 32'h1234_5678;
    @(negedge clk);
    check("gpio_latch", gpio_in_s_insp, 32'hDEAD_BEEF);

    // 3 * 5
    bus_write(BASE, 32'd3);
    bus_write(BASE + 16'h08, 32'd5);
    bus_write(BASE + 16'h20, 32'h1);
    bus_read(BASE + 16'h20, d); check("t2_status_busy", d, 32'h4);
    finish_op("t2");
    bus_read(BASE + 16'h20, d); check("t2_status", d, 32'h3);
    bus_read(BASE + 16'h10, d); check("t2_W", d, 32'd15);
    bus_read(BASE + 16'h18, d); check("t2_L", d, 32'd4);
    check("t2_gpio_out", gpio_out, 32'h1);
    bus_read(BASE + 16'h04, d); check("unmapped_04", d, 32'h0);
    bus_read(BASE, d);          check("read_A1_wo", d, 32'h0);

    // full-scale operands; upper write bits must be ignored
    bus_write(BASE, 32'hFFFF_FFFF);
    bus_write(BASE + 16'h08, 32'hFFFF_FFFF);
    bus_write(BASE + 16'h20, 32'h1);
    finish_op("t3");
    bus_read(BASE + 16'h10, d); check("t3_W", d, 32'hFE00_0001);
    bus_read(BASE + 16'h18, d); check("t3_L", d, 32'd24);
    bus_read(BASE + 16'h20, d); check("t3_status", d, 32'h2);
    bus_read(BASE + 16'h28, d);
`ifdef MULPOP_HIWORD_EN
    check("t3_hiword", d, 32'h0000_FFFF);
`else
    check("t3_hiword_unmapped", d, 32'h0);
`endif
    check("t3_gpio_out", gpio_out, 32'h2);

    // start while busy -> overrun
    bus_write(BASE, 32'd3);
    bus_write(BASE + 16'h08, 32'd5);
    bus_write(BASE + 16'h20, 32'h1);
    @(negedge clk);
    bus_write(BASE + 16'h20, 32'h1);
    bus_read(BASE + 16'h20, d); check("t4_status_busy", d, 32'hC);
    finish_op("t4");
    bus_read(BASE + 16'h20, d); check("t4_status", d, 32'hB);
    check("t4_gpio_out", gpio_out, 32'h3);

    // reset mid-operation
    bus_write(BASE + 16'h20, 32'h1);
    repeat (8) @(negedge clk);
    n_reset = 1'b0;
    @(negedge clk);
    n_reset = 1'b1;
    check("t5_gpio_out", gpio_out, 32'h0);
    bus_read(BASE + 16'h20, d); check("t5_status", d, 32'h3);
    bus_read(BASE + 16'h10, d); check("t5_W", d, 32'h0);
    bus_write(BASE, 32'd2);
    bus_write(BASE + 16'h08, 32'd7);
    bus_write(BASE + 16'h20, 32'h1);
    finish_op("t5b");
    bus_read(BASE + 16'h10, d); check("t5b_W", d, 32'd14);
    bus_read(BASE + 16'h18, d); check("t5b_L", d, 32'd3);
    check("t5b_gpio_out", gpio_out, 32'h1);

    // operand snapshot: A1 written while busy does not affect running op
    bus_write(BASE, 32'd0);
    bus_write(BASE + 16'h08, 32'h00AB_CDEF);
    bus_write(BASE + 16'h20, 32'h1);
    bus_write(BASE, 32'd9);
    finish_op("t6");
    bus_read(BASE + 16'h10, d); check("t6_W", d, 32'h0);
    bus_read(BASE + 16'h18, d); check("t6_L", d, 32'h0);
    bus_read(BASE + 16'h20, d); check("t6_status", d, 32'h3);
    // same-cycle read and start on status: read returns pre-start value
    bus_rw(BASE + 16'h20, 32'h1, d); check("t6b_rw_status", d, 32'h3);
    bus_read(BASE + 16'h20, d); check("t6b_status_busy", d, 32'h4);
    finish_op("t6b");
    bus_read(BASE + 16'h10, d); check("t6b_W", d, 32'h060A_3D67);
    bus_read(BASE + 16'h18, d); check("t6b_L", d, 32'd14);
    bus_read(BASE + 16'h20, d); check("t6b_status", d, 32'h3);
    check("t6b_gpio_out", gpio_out, 32'h3);

    @(negedge clk);
    chk_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
